// File: rtl/lfsr_share_arbiter_pkg.sv
// Shared definitions for the LFSR share arbiter: FSM state encoding,
// requester count limit, default reseed value and a pointer-width helper.
package lfsr_share_arbiter_pkg;

  // Arbiter FSM states. IDLE is the only state that samples requests.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_STEP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESEED = 3'd4
  } arb_state_t;

  // Largest supported number of requesters.
  localparam int N_REQ_MAX = 8;

  // Default random word width and reseed value.
  // The reseed value must be non-zero so the LFSR leaves lockup.
  localparam int DEFAULT_WIDTH = 7;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_SEED = 7'h01;

  // Width of a round-robin pointer able to address n requesters.
  function automatic int ptrWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lfsr_share_arbiter_rr_pick.sv
// Combinational round-robin winner select. Searches upward from the
// pointer with wrap-around and returns the first requesting index.
module rr_pick
  import lfsr_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_rrPtr,
  output logic [N_REQ-1:0] o_winner,
  output logic [PTR_W-1:0] o_winnerIdx,
  output logic             o_anyReq
);

  logic             w_hiHit;
  logic [PTR_W-1:0] w_hiIdx;
  logic             w_loHit;
  logic [PTR_W-1:0] w_loIdx;

  // Lowest request at or above the pointer wins; otherwise the lowest
  // request below it (the wrapped part of the search).
  always_comb begin
    w_hiHit     = 1'b0;
    w_hiIdx     = '0;
    w_loHit     = 1'b0;
    w_loIdx     = '0;
    o_winner    = '0;
    o_winnerIdx = '0;
    o_anyReq    = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        if (j >= int'(i_rrPtr)) begin
          w_hiHit = 1'b1;
          w_hiIdx = PTR_W'(j);
        end else begin
          w_loHit = 1'b1;
          w_loIdx = PTR_W'(j);
        end
      end
    end
    o_anyReq    = w_hiHit | w_loHit;
    o_winnerIdx = w_hiHit ? w_hiIdx : w_loIdx;
    if (o_anyReq) begin
      o_winner[o_winnerIdx] = 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_share_arbiter.sv
// Shares one external LFSR among N_REQ requesters. Each grant hands the
// current LFSR word to one requester, then steps the LFSR and waits one
// cycle so the next capture always sees a fresh state. A zero LFSR state
// (lockup) is repaired by pulsing seed_load before any further grant.
module lfsr_share_arbiter
  import lfsr_share_arbiter_pkg::*;
#(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter int               N_REQ = 4,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             ADC_CLK_10,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] rnd_in,
  output logic [N_REQ-1:0] gnt,
  output logic             valid,
  output logic [WIDTH-1:0] rnd_out,
  output logic             lfsr_step,
  output logic             seed_load,
  output logic [WIDTH-1:0] seed_val
);

  localparam int PTR_W = ptrWidth(N_REQ);

  if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : gBadNReq
    $error("lfsr_share_arbiter: N_REQ out of range");
  end

  arb_state_t       r_state;
  arb_state_t       w_stateNext;
  logic [PTR_W-1:0] r_rrPtr;
  logic [PTR_W-1:0] w_rrPtrNext;
  logic [N_REQ-1:0] r_gnt;
  logic             r_valid;
  logic [WIDTH-1:0] r_rndOut;
  logic             r_lfsrStep;
  logic             r_seedLoad;

  logic [N_REQ-1:0] w_winner;
  logic [PTR_W-1:0] w_winnerIdx;
  logic             w_anyReq;
  logic             w_grantFire;
  logic             w_reseedFire;
  logic             w_stepFire;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rrPick (
    .i_req       (req),
    .i_rrPtr     (r_rrPtr),
    .o_winner    (w_winner),
    .o_winnerIdx (w_winnerIdx),
    .o_anyReq    (w_anyReq)
  );

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_comb begin
    w_rrPtrNext = r_rrPtr;
    if (w_grantFire) begin
      if (w_winnerIdx == PTR_W'(N_REQ - 1)) begin
        w_rrPtrNext = '0;
      end else begin
        w_rrPtrNext = w_winnerIdx + 1'b1;
      end
    end
  end

  // Next-state logic; lockup repair in IDLE outranks pending requests.
  always_comb begin
    w_stateNext  = r_state;
    w_grantFire  = 1'b0;
    w_reseedFire = 1'b0;
    w_stepFire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rnd_in == '0) begin
          w_stateNext  = ST_RESEED;
          w_reseedFire = 1'b1;
        end else if (w_anyReq) begin
          w_stateNext = ST_GRANT;
          w_grantFire = 1'b1;
        end
      end
      ST_GRANT: begin
        w_stateNext = ST_STEP;
        w_stepFire  = 1'b1;
      end
      ST_STEP:   w_stateNext = ST_SETTLE;
      ST_SETTLE: w_stateNext = ST_IDLE;
      ST_RESEED: w_stateNext = ST_SETTLE;
      default:   w_stateNext = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      r_rrPtr <= '0;
    end else begin
      r_rrPtr <= w_rrPtrNext;
    end
  end

  // Grant outputs: one-hot grant and valid are high only in GRANT.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_gnt   <= w_grantFire ? w_winner : '0;
      r_valid <= w_grantFire;
    end
  end

  // Captured word is held between grants so it stays readable afterwards.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      r_rndOut <= '0;
    end else if (w_grantFire) begin
      r_rndOut <= rnd_in;
    end
  end

  // LFSR control pulses: step in STEP, seed load in RESEED, one cycle each.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsrStep <= 1'b0;
      r_seedLoad <= 1'b0;
    end else begin
      r_lfsrStep <= w_stepFire;
      r_seedLoad <= w_reseedFire;
    end
  end

  assign gnt       = r_gnt;
  assign valid     = r_valid;
  assign rnd_out   = r_rndOut;
  assign lfsr_step = r_lfsrStep;
  assign seed_load = r_seedLoad;
  assign seed_val  = SEED;

endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// Self-checking bench for lfsr_share_arbiter. A stand-in for the shared
// LFSR counts up by one per lfsr_step and loads seed_val on seed_load, so
// the words each grant should capture can be worked out by hand.
module tb_lfsr_share_arbiter;

  localparam int WIDTH = 7;
  localparam int N_REQ = 4;

  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] rnd;
  } exp_t;

  logic             ADC_CLK_10 = 1'b0;
  logic             reset_n    = 1'b1;
  logic [N_REQ-1:0] req        = '0;
  logic [WIDTH-1:0] rnd_in;
  logic [N_REQ-1:0] gnt;
  logic             valid;
  logic [WIDTH-1:0] rnd_out;
  logic             lfsr_step;
  logic             seed_load;
  logic [WIDTH-1:0] seed_val;

  logic [WIDTH-1:0] rndModel       = 7'h2A;
  logic             rndOverride    = 1'b0;
  logic [WIDTH-1:0] rndOverrideVal = '0;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  lfsr_share_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ),
    .SEED  (7'h01)
  ) dut (
    .ADC_CLK_10 (ADC_CLK_10),
    .reset_n    (reset_n),
    .req        (req),
    .rnd_in     (rnd_in),
    .gnt        (gnt),
    .valid      (valid),
    .rnd_out    (rnd_out),
    .lfsr_step  (lfsr_step),
    .seed_load  (seed_load),
    .seed_val   (seed_val)
  );

  always #5 ADC_CLK_10 = ~ADC_CLK_10;

  // LFSR stand-in: a forced value wins, otherwise the counter state.
  assign rnd_in = rndOverride ? rndOverrideVal : rndModel;

  always @(posedge ADC_CLK_10) begin
    if (seed_load) begin
      rndModel <= seed_val;
    end else if (lfsr_step) begin
      rndModel <= rndModel + 7'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitValid(output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge ADC_CLK_10);
      #1;
      cycles++;
      if (valid) seen = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] mask,
                               input logic [N_REQ-1:0] expGnt,
                               input logic [WIDTH-1:0] expRnd,
                               input string name);
    bit seen;
    int cycles;
    expQ.push_back('{gnt: expGnt, rnd: expRnd});
    req = mask;
    waitValid(seen, cycles);
    checkOutput(name, 32'(seen), 32'd1);
    req = '0;
  endtask

  task automatic applyReset();
    @(posedge ADC_CLK_10);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge ADC_CLK_10);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every valid and checks pulse rules.
  initial begin
    bit   prevValid  = 1'b0;
    bit   seenValid  = 1'b0;
    int   sinceValid = 0;
    exp_t e;
    forever begin
      @(negedge ADC_CLK_10);
      if (!reset_n) begin
        prevValid  = 1'b0;
        seenValid  = 1'b0;
        sinceValid = 0;
      end else begin
        sinceValid++;
        checkOutput("stepAfterValid", 32'(lfsr_step), 32'(prevValid));
        checkOutput("stepSeedExclusive", 32'(lfsr_step & seed_load), 32'd0);
        if (!valid) checkOutput("gntIdle", 32'(gnt), 32'd0);
        if (valid) begin
          if (seenValid) begin
            checks++;
            if (sinceValid < 4) begin
              errors++;
              $display("[TB] FAIL grantGap: got %0d cycles, expected >= 4", sinceValid);
            end
          end
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpectedValid: got gnt=0x%0h rnd=0x%0h, expected no grant",
                     gnt, rnd_out);
          end else begin
            e = expQ.pop_front();
            if (gnt !== e.gnt || rnd_out !== e.rnd) begin
              errors++;
              $display("[TB] FAIL grant: got gnt=0x%0h rnd=0x%0h, expected gnt=0x%0h rnd=0x%0h",
                       gnt, rnd_out, e.gnt, e.rnd);
            end
          end
          seenValid  = 1'b1;
          sinceValid = 0;
        end
        prevValid = valid;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    bit seen;
    int cycles;
    bit sawValid;

    #1 reset_n = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rstGnt", 32'(gnt), 32'd0);
    checkOutput("rstValid", 32'(valid), 32'd0);
    checkOutput("rstRndOut", 32'(rnd_out), 32'd0);
    checkOutput("rstStep", 32'(lfsr_step), 32'd0);
    checkOutput("rstSeedLoad", 32'(seed_load), 32'd0);
    checkOutput("seedVal", 32'(seed_val), 32'h01);
    repeat (2) @(posedge ADC_CLK_10);
    #1 reset_n = 1'b1;

    $display("[TB] single request");
    applyStimulus(4'b0100, 4'b0100, 7'h2A, "t1Grant");
    @(posedge ADC_CLK_10);
    #1 checkOutput("t1StepHigh", 32'(lfsr_step), 32'd1);
    @(posedge ADC_CLK_10);
    #1 checkOutput("t1StepLow", 32'(lfsr_step), 32'd0);

    $display("[TB] round robin");
    applyReset();
    expQ.push_back('{gnt: 4'b0001, rnd: 7'h2B});
    expQ.push_back('{gnt: 4'b0010, rnd: 7'h2C});
    expQ.push_back('{gnt: 4'b0100, rnd: 7'h2D});
    expQ.push_back('{gnt: 4'b1000, rnd: 7'h2E});
    expQ.push_back('{gnt: 4'b0001, rnd: 7'h2F});
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      waitValid(seen, cycles);
      checkOutput("rrSeen", 32'(seen), 32'd1);
      if (k > 0) checkOutput("rrSpacing", 32'(cycles), 32'd4);
    end
    req = '0;

    $display("[TB] wrap-around");
    applyStimulus(4'b0100, 4'b0100, 7'h30, "wrapPrime");
    applyStimulus(4'b0001, 4'b0001, 7'h31, "wrapGrant");

    $display("[TB] lockup reseed");
    repeat (4) @(posedge ADC_CLK_10);
    #1;
    rndOverride    = 1'b1;
    rndOverrideVal = '0;
    req            = 4'b0010;
    expQ.push_back('{gnt: 4'b0010, rnd: 7'h01});
    @(posedge ADC_CLK_10);
    #1;
    checkOutput("lockSeedLoad", 32'(seed_load), 32'd1);
    checkOutput("lockNoValid", 32'(valid), 32'd0);
    checkOutput("lockNoGnt", 32'(gnt), 32'd0);
    rndOverride = 1'b0;
    @(posedge ADC_CLK_10);
    #1 checkOutput("lockSeedPulse", 32'(seed_load), 32'd0);
    waitValid(seen, cycles);
    checkOutput("lockGrantSeen", 32'(seen), 32'd1);
    req = '0;

    $display("[TB] reset mid-grant");
    req = 4'b1000;
    waitValid(seen, cycles);
    checkOutput("midSeen", 32'(seen), 32'd1);
    checkOutput("midGnt", 32'(gnt), 32'h8);
    checkOutput("midRnd", 32'(rnd_out), 32'h02);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstGnt", 32'(gnt), 32'd0);
    checkOutput("midRstValid", 32'(valid), 32'd0);
    repeat (2) begin
      @(posedge ADC_CLK_10);
      #1 checkOutput("midRstNoStep", 32'(lfsr_step), 32'd0);
    end
    expQ.push_back('{gnt: 4'b1000, rnd: 7'h02});
    reset_n = 1'b1;
    waitValid(seen, cycles);
    checkOutput("postRstGrant", 32'(seen), 32'd1);
    req = '0;

    $display("[TB] dropped request");
    applyStimulus(4'b0001, 4'b0001, 7'h03, "dropSetup");
    @(posedge ADC_CLK_10);
    #1;
    checkOutput("dropInStep", 32'(lfsr_step), 32'd1);
    req = 4'b0100;
    @(posedge ADC_CLK_10);
    #1 req = '0;
    sawValid = 1'b0;
    repeat (12) begin
      @(posedge ADC_CLK_10);
      #1 if (valid) sawValid = 1'b1;
    end
    checkOutput("droppedReq", 32'(sawValid), 32'd0);
    checkOutput("rndOutHold", 32'(rnd_out), 32'h03);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_share_arbiter.md
LFSR_SHARE_ARBITER -- requirements
Module: lfsr_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 7: random word width in bits.
REQ-002 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter SEED, default 7'h01 (WIDTH bits, non-zero): value driven for LFSR reseed.
REQ-004 ADC_CLK_10  in  1: single system clock; all state on its rising edge.
REQ-005 reset_n  in  1: reset, asynchronous assert, active-low.
REQ-006 req  in  N_REQ: level request per requester, held high until that requester's valid cycle.
REQ-007 rnd_in  in  WIDTH: current LFSR state from the shared LFSR instance.
REQ-008 gnt  out  N_REQ: one-hot grant, high for exactly the valid cycle.
REQ-009 valid  out  1: single-cycle pulse; rnd_out is meaningful only while high.
REQ-010 rnd_out  out  WIDTH: captured random word delivered to the granted requester.
REQ-011 lfsr_step  out  1: single-cycle enable to advance the shared LFSR by one state.
REQ-012 seed_load  out  1: single-cycle pulse to load seed_val into the LFSR.
REQ-013 seed_val  out  WIDTH: constant SEED.

Function
REQ-014 FSM states: IDLE, GRANT, STEP, SETTLE, RESEED.
- IDLE: if rnd_in == 0, go to RESEED. Else if req != 0, go to GRANT. Else stay in IDLE.
- GRANT -> STEP -> SETTLE -> IDLE, unconditional.
- RESEED -> SETTLE, unconditional.
REQ-015 IDLE -> GRANT edge registers:
- gnt <= one-hot winner;
- rnd_out <= rnd_in;
- valid <= 1.
Latency: req sampled high at edge t gives valid high during cycle t+1.
REQ-016 Winner = first set req bit at or above rr_ptr, searching upward with wrap-around modulo N_REQ.
REQ-017 On each grant, rr_ptr <= (winner index + 1) mod N_REQ. rr_ptr is unchanged otherwise.
REQ-018 GRANT -> STEP edge: valid <= 0, gnt <= 0, lfsr_step <= 1. lfsr_step is high for exactly one cycle.
REQ-019 STEP -> SETTLE edge: lfsr_step <= 0. SETTLE lets rnd_in update before the next capture.
- Maximum throughput: one grant per 4 cycles.
- No requester ever receives the same LFSR state as the previous grant.
REQ-020 IDLE with rnd_in == 0 (lockup):
- seed_load pulses for one cycle (the RESEED cycle);
- no grant is issued;
- pending requests wait; RESEED takes priority over req.
REQ-021 Request handling:
- A requester that deasserts req before being granted is silently dropped.
- req high again in the cycle after its valid counts as a new request at round-robin priority.
REQ-022 Requests arriving in GRANT, STEP, SETTLE or RESEED are not lost if held; they are sampled at the next IDLE.
REQ-023 gnt is zero outside GRANT. lfsr_step and seed_load are never high in the same cycle.
REQ-024 rnd_out holds its last captured value between grants.

Reset
REQ-025 reset_n low sets, asynchronously:
- state = IDLE, rr_ptr = 0;
- gnt = 0, valid = 0, rnd_out = 0;
- lfsr_step = 0, seed_load = 0.
REQ-026 Reset asserted mid-transaction aborts it. No valid, lfsr_step or seed_load pulse may follow until a fresh IDLE sample.
REQ-027 First decision after reset release is on the first rising edge with reset_n high.

Structure
REQ-028 Shared package holds:
- state enum type;
- N_REQ maximum;
- default SEED constant.
REQ-029 One sub-module, rr_pick: combinational round-robin winner select with inputs req and rr_ptr, outputs one-hot winner and index. Everything else is flat in lfsr_share_arbiter.
REQ-030 The LFSR and clock divider stay outside this block. The top level wires rnd_in, lfsr_step, seed_load and seed_val to the LFSR.

Verification
REQ-031 Single request:
- Stimulus: reset, rnd_in=7'h2A, req=4'b0100 at edge t.
- Response: cycle t+1 gnt=4'b0100, valid=1, rnd_out=7'h2A; cycle t+2 lfsr_step=1; next grant no earlier than t+4.
REQ-032 Round-robin:
- Stimulus: req=4'b1111 held for 16 cycles.
- Response: grants in order 0,1,2,3,0; exactly one grant per 4 cycles.
REQ-033 Wrap-around:
- Stimulus: rr_ptr=3 after a grant to index 2, then req=4'b0001.
- Response: index 0 granted (search wraps past 3).
REQ-034 Lockup:
- Stimulus: rnd_in=0 in IDLE with req=4'b0010.
- Response: seed_load=1 for one cycle, seed_val=7'h01, no valid; grant to index 1 follows once rnd_in != 0.
REQ-035 Reset mid-grant:
- Stimulus: reset_n low during GRANT.
- Response: gnt=0 and valid=0 immediately, with no lfsr_step afterwards; after release, req=4'b1000 is granted with rr_ptr=0 semantics.
REQ-036 Dropped request:
- Stimulus: req[2] pulses for one cycle while the FSM is in STEP.
- Response: no grant to index 2.
